// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state type and default timing constants for the stopwatch front end
package stopwatch_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    LAP     = 2'd2
  } sw_state_t;

  localparam int DB_CYCLES_DEFAULT = 1_000_000;
  localparam int TICK_DIV_DEFAULT  = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - raw button synchronizer, debounce filter and registered press pulse
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  // sync_q[0] registers the pin, sync_q[2:1] is the two-flop synchronizer proper
  logic [2:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          press_q, press_d;

  // Count consecutive cycles the synced level disagrees with the accepted level; accept after DB_CYCLES
  always_comb begin
    sync_d      = {sync_q[1:0], btn_raw};
    cnt_d       = '0;
    level_d     = level_q;
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;
    if (sync_q[2] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[2];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset drops any partial debounce progress
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch button conditioning, run/lap FSM and tick prescaler (lap option: STOPWATCH_LAP_EN)
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int TICK_DIV  = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_ss,
  input  logic btn_clr,
  input  logic btn_lap,
  output logic running,
  output logic tick,
  output logic clear,
  output logic freeze
);

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic ss_press;
  logic clr_press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_ss),
    .press   (ss_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_clr),
    .press   (clr_press)
  );

`ifdef STOPWATCH_LAP_EN
  logic lap_press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_lap),
    .press   (lap_press)
  );
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;
`endif

  sw_state_t     state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          running_q, running_d;
  logic          tick_q, tick_d;
  logic          clear_q, clear_d;
  logic          advance;

  // Next state with ss > lap > clr priority; the prescaler only advances while running before and after the edge
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      STOPPED: begin
        if (ss_press) begin
          state_d = RUNNING;
        end else if (clr_press) begin
          clear_d = 1'b1;
        end
      end
      RUNNING: begin
        if (ss_press) begin
          state_d = STOPPED;
        end
`ifdef STOPWATCH_LAP_EN
        else if (lap_press) begin
          state_d = LAP;
        end
`endif
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (ss_press) begin
          state_d = STOPPED;
        end else if (lap_press) begin
          state_d = RUNNING;
        end
      end
`endif
      default: state_d = STOPPED;
    endcase

    running_d = (state_d != STOPPED);
    advance   = running_q & running_d;
    tick_d    = advance & (pre_q == PRE_LAST);

    pre_d = pre_q;
    if (clear_d) begin
      pre_d = '0;
    end else if (advance) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end
  end

  // Control registers; every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= STOPPED;
      pre_q     <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      clear_q   <= clear_d;
    end
  end

  assign running = running_q;
  assign tick    = tick_q;
  assign clear   = clear_q;

`ifdef STOPWATCH_LAP_EN
  logic freeze_q, freeze_d;

  // Display hold follows the LAP state
  always_comb begin
    freeze_d = (state_d == LAP);
  end

  // Freeze register
  always_ff @(posedge clk) begin
    if (reset) begin
      freeze_q <= 1'b0;
    end else begin
      freeze_q <= freeze_d;
    end
  end

  assign freeze = freeze_q;
`else
  assign freeze = 1'b0;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-end control stage of the stopwatch: conditions the raw start/stop, clear and lap push-buttons and generates the count-enable tick stream and clear pulse that drive the BCD digit counter. It sits directly upstream of the digit counter, which increments its d0..d3 digits on `tick` and zeroes them on `clear`. The lap feature freezes the displayed value while timing continues.

## Interface
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- `TICK_DIV`, default 1_000_000: clock cycles per `tick` while running (100 Hz at 100 MHz).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_ss`  in  1  raw asynchronous start/stop button, active-high.
- `btn_clr`  in  1  raw asynchronous clear button, active-high.
- `btn_lap`  in  1  raw asynchronous lap button, active-high. Present in all builds.
- `running`  out  1  high while the timebase advances.
- `tick`  out  1  one-cycle count-enable pulse to the digit counter.
- `clear`  out  1  one-cycle pulse that zeroes the digit counter.
- `freeze`  out  1  high while the display is held at the lap value.

## Operation
- Each button: 2-flop synchronizer, then debounce.
  - Counter resets to 0 when the synced level equals the debounced level; otherwise it increments.
  - When the counter reaches DB_CYCLES-1 with the level still differing, the debounced level flips on the next edge and the counter returns to 0.
  - On a debounced 0->1 transition, a registered one-cycle `press` pulse is produced. Releases produce no pulse.
- FSM states, reset value STOPPED:
  - STOPPED: `ss` press -> RUNNING. `clr` press -> pulse `clear`, zero the prescaler, stay in STOPPED.
  - RUNNING: `ss` press -> STOPPED. `lap` press -> LAP. `clr` is ignored.
  - LAP: same as RUNNING, with `freeze`=1. `lap` press -> RUNNING. `ss` press -> STOPPED, releasing `freeze`. `clr` is ignored.
- Priority for same-cycle presses: `ss` > `lap` > `clr`. Only the winning press acts; the others are discarded, not queued.
- Prescaler, width $clog2(TICK_DIV):
  - Advances only when `running`=1. When the count equals TICK_DIV-1, `tick`=1 for that cycle and the count wraps to 0.
  - Holds its value while stopped, so the fractional period is preserved across pause and resume.
  - Cleared to 0 only by reset or `clear`.
- `running` = state is RUNNING or LAP. The prescaler keeps ticking in LAP.
- Reset values: `running`=0, `tick`=0, `clear`=0, `freeze`=0. The prescaler, debounce counters and debounced levels are all 0. Reset mid-press discards all partial debounce progress.

## Timing
- Raw level first sampled high at edge k:
  - synced level at k+2
  - debounced level at k+2+DB_CYCLES
  - `press` at k+3+DB_CYCLES
  - state and `running`/`freeze` update at k+4+DB_CYCLES
- `clear` is asserted at k+4+DB_CYCLES, for exactly one cycle. The prescaler reads 0 on the following cycle.
- The first `tick` after a resume from zero comes TICK_DIV cycles after `running` rises. `tick` is registered and never asserts while `running`=0.
- Glitches shorter than DB_CYCLES cycles produce no `press`.
- All outputs are registered.

## Configuration
- `STOPWATCH_LAP_EN` defined: LAP state, `btn_lap` conditioning and `freeze` are compiled in as described above.
- `STOPWATCH_LAP_EN` undefined:
  - No LAP state and no lap debouncer; `btn_lap` is ignored.
  - `freeze` is tied to 0.
  - All other behaviour is identical.

## Structure
- `stopwatch_pkg` holds:
  - the FSM state enum typedef `sw_state_t` (STOPPED, RUNNING, LAP)
  - default constants for DB_CYCLES and TICK_DIV
- Sub-module `btn_debounce` (synchronizer, debounce counter and press pulse, parameterized by DB_CYCLES) is instantiated once per button.

## Test plan
All scenarios use DB_CYCLES=4, TICK_DIV=5.
- Reset, then idle 20 cycles -> all outputs 0, no `tick`.
- Hold `btn_ss` high for 12 cycles starting at edge 10 -> `running` rises at edge 18. `tick` pulses at edges 23, 28, 33 and then every 5 cycles.
- While running, apply `btn_ss` glitches of 3 cycles -> no state change. Then a clean 10-cycle press -> `running` falls. The prescaler holds (e.g. 2); on resume, the first `tick` comes 3 cycles after `running` rises.
- Press `btn_clr` while running -> no `clear`. Press it while stopped -> one-cycle `clear`, and the next resume gives its first `tick` 5 cycles after `running` rises.
- `btn_ss` and `btn_clr` pressed in the same cycle while stopped -> `running`=1 and no `clear` pulse.
- With `STOPWATCH_LAP_EN`:
  - lap press while running -> `freeze`=1 while `tick` continues
  - second lap press -> `freeze`=0
  - lap press then `ss` press -> `running`=0 and `freeze`=0
  - assert `reset` while in LAP -> all outputs 0 the next cycle
